// File: rtl/mfp_uart_tx.sv
// Atari ST MFP USART bit-level transmitter: pops bytes from the output FIFO and serialises them per UCR.
// Optional break generation is compiled in with `define MFP_UART_TX_BREAK_EN.
`timescale 1ns/1ps

module mfp_uart_tx (
    input  logic       clk_32,
    input  logic       reset,
    input  logic       baud_tick,
    input  logic [6:0] ucr,
    input  logic       tx_enable,
    input  logic       tx_break,
    input  logic       fifo_avail,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [1:0] FMT_SYNC    = 2'b00;
    localparam logic [1:0] FMT_STOP1P5 = 2'b10;
    localparam logic [1:0] FMT_STOP2   = 2'b11;

    logic [2:0] state_q,    state_d;
    logic       txd_q,      txd_d;
    logic [7:0] shift_q,    shift_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [4:0] tick_cnt_q, tick_cnt_d;
    logic       parity_q,   parity_d;
    logic       div16_q,    div16_d;
    logic [1:0] wordlen_q,  wordlen_d;
    logic [1:0] format_q,   format_d;
    logic       par_en_q,   par_en_d;
    logic       even_q,     even_d;

    logic [4:0] bit_last;
    logic [4:0] stop_last;
    logic [2:0] data_last;
    logic       parity_acc;
    logic       start_ok;
    logic       pop_raw;
    logic       done_raw;

    // Frame geometry comes from the snapshot, so a UCR write mid-frame is harmless.
    assign bit_last   = div16_q ? 5'd15 : 5'd0;
    assign data_last  = 3'd7 - {1'b0, wordlen_q};
    assign parity_acc = parity_q ^ shift_q[0];

    always_comb begin
        unique case (format_q)
            FMT_STOP1P5: stop_last = div16_q ? 5'd23 : 5'd1;
            FMT_STOP2:   stop_last = div16_q ? 5'd31 : 5'd1;
            default:     stop_last = div16_q ? 5'd15 : 5'd0;
        endcase
    end

`ifdef MFP_UART_TX_BREAK_EN
    logic break_req;

    assign break_req = tx_enable && tx_break;
    // A released break must show one idle-high cycle before the next start bit.
    assign start_ok  = tx_enable && fifo_avail && (ucr[3:2] != FMT_SYNC) && !tx_break && txd_q;
`else
    logic unused_tx_break;

    assign unused_tx_break = tx_break;
    assign start_ok        = tx_enable && fifo_avail && (ucr[3:2] != FMT_SYNC);
`endif

    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        tick_cnt_d = tick_cnt_q;
        parity_d   = parity_q;
        div16_d    = div16_q;
        wordlen_d  = wordlen_q;
        format_d   = format_q;
        par_en_d   = par_en_q;
        even_d     = even_q;
        pop_raw    = 1'b0;
        done_raw   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
`ifdef MFP_UART_TX_BREAK_EN
                if (break_req) begin
                    txd_d = 1'b0;
                end
`endif
                if (start_ok) begin
                    pop_raw    = 1'b1;
                    state_d    = ST_START;
                    txd_d      = 1'b0;
                    shift_d    = fifo_data;
                    bit_cnt_d  = 3'd0;
                    tick_cnt_d = 5'd0;
                    parity_d   = 1'b0;
                    div16_d    = ucr[6];
                    wordlen_d  = ucr[5:4];
                    format_d   = ucr[3:2];
                    par_en_d   = ucr[1];
                    even_d     = ucr[0];
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    if (tick_cnt_q == bit_last) begin
                        state_d    = ST_DATA;
                        tick_cnt_d = 5'd0;
                        txd_d      = shift_q[0];
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    if (tick_cnt_q == bit_last) begin
                        tick_cnt_d = 5'd0;
                        parity_d   = parity_acc;
                        shift_d    = {1'b0, shift_q[7:1]};
                        if (bit_cnt_q == data_last) begin
                            if (par_en_q) begin
                                state_d = ST_PARITY;
                                txd_d   = even_q ? parity_acc : ~parity_acc;
                            end else begin
                                state_d = ST_STOP;
                                txd_d   = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            txd_d     = shift_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (baud_tick) begin
                    if (tick_cnt_q == bit_last) begin
                        state_d    = ST_STOP;
                        tick_cnt_d = 5'd0;
                        txd_d      = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end

            ST_STOP: begin
                if (baud_tick) begin
                    if (tick_cnt_q == stop_last) begin
                        state_d    = ST_IDLE;
                        tick_cnt_d = 5'd0;
                        done_raw   = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Strobes are masked during reset so the IRQ and FIFO never see a stray pulse.
    assign fifo_pop = pop_raw && !reset;
    assign tx_done  = done_raw && !reset;
    assign tx_busy  = (state_q != ST_IDLE) && !tx_done;
    assign txd      = txd_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk_32) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            txd_q      <= 1'b1;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            tick_cnt_q <= 5'd0;
            parity_q   <= 1'b0;
            div16_q    <= 1'b0;
            wordlen_q  <= 2'b00;
            format_q   <= 2'b00;
            par_en_q   <= 1'b0;
            even_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            parity_q   <= parity_d;
            div16_q    <= div16_d;
            wordlen_q  <= wordlen_d;
            format_q   <= format_d;
            par_en_q   <= par_en_d;
            even_q     <= even_d;
        end
    end

    pop_never_back_to_back: assert property (@(posedge clk_32) disable iff (reset)
        fifo_pop |=> !fifo_pop);

    pop_not_with_done: assert property (@(posedge clk_32) disable iff (reset)
        !(fifo_pop && tx_done));

endmodule

// File: tb/tb_mfp_uart_tx.sv
// Scoreboard bench for mfp_uart_tx: directed frames push expected bit lists; a monitor checks txd per frame.
// Expected bit vectors hold the first-transmitted bit (the start bit) in bit 0.
`timescale 1ns/1ps

module tb_mfp_uart_tx;

    logic       clk_32     = 1'b0;
    logic       reset      = 1'b1;
    logic       baud_tick  = 1'b0;
    logic [6:0] ucr        = 7'd0;
    logic       tx_enable  = 1'b0;
    logic       tx_break   = 1'b0;
    logic       fifo_avail = 1'b0;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_pop;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    mfp_uart_tx dut (
        .clk_32     (clk_32),
        .reset      (reset),
        .baud_tick  (baud_tick),
        .ucr        (ucr),
        .tx_enable  (tx_enable),
        .tx_break   (tx_break),
        .fifo_avail (fifo_avail),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk_32 = ~clk_32;

    typedef struct {
        int          nb;        // start + data + parity bits
        logic [15:0] bits;
        int          bclk;      // clk_32 cycles per bit
        int          stop_clk;  // clk_32 cycles of stop level up to and including tx_done
        bit          abort;     // frame is expected to be cut short by reset
    } frame_t;

    frame_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int pop_seen = 0;
    int done_seen = 0;
    int exp_pops = 0;
    int exp_dones = 0;
    int tick_period = 1;
    int tick_cnt = 0;

    localparam logic [6:0] UCR_8N1_D16  = 7'b1_00_01_0_0;
    localparam logic [6:0] UCR_7E2_D16  = 7'b1_01_11_1_1;
    localparam logic [6:0] UCR_5O15_D1  = 7'b0_11_10_1_0;
    localparam logic [6:0] UCR_8N1_D1   = 7'b0_00_01_0_0;
    localparam logic [6:0] UCR_SYNC     = 7'b0_00_00_0_0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    function automatic frame_t mk(input int nb, input logic [15:0] bits, input int bclk,
                                  input int stop_clk, input bit abort);
        frame_t f;
        f.nb = nb; f.bits = bits; f.bclk = bclk; f.stop_clk = stop_clk; f.abort = abort;
        return f;
    endfunction

    // Free-running Timer D model: one-cycle pulse every tick_period clocks.
    initial begin
        forever begin
            @(posedge clk_32);
            #1;
            tick_cnt  = (tick_cnt + 1 >= tick_period) ? 0 : tick_cnt + 1;
            baud_tick = (tick_cnt == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk_32);
            if (fifo_pop) pop_seen++;
            if (tx_done) done_seen++;
        end
    end

    task automatic check_frame();
        frame_t f;
        int c = 0;
        bit ended = 0;
        bit aborted = 0;
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'(exp_q.size()), 1);
            return;
        end
        f = exp_q.pop_front();
        while (!ended && c <= 4000) begin
            if (reset) begin
                aborted = 1;
                ended = 1;
            end else begin
                for (int k = 0; k < f.nb; k++)
                    if (c == k * f.bclk + f.bclk / 2)
                        check($sformatf("frame_bit%0d", k), txd, f.bits[k]);
                if (c == f.nb * f.bclk + f.stop_clk / 2)
                    check("stop_level", txd, 1);
                if (tx_done) begin
                    check("frame_len", c, f.nb * f.bclk + f.stop_clk - 1);
                    ended = 1;
                end
            end
            if (!ended) begin
                @(negedge clk_32);
                c++;
            end
        end
        check("frame_ended", ended, 1);
        check("frame_end_by_reset", aborted, f.abort);
    endtask

    initial begin
        bit prev_busy = 0;
        forever begin
            @(negedge clk_32);
            if (tx_busy && !prev_busy && !reset) check_frame();
            prev_busy = tx_busy;
        end
    end

    task automatic align_tick();
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(posedge clk_32);
            #2;
            found = baud_tick;
        end
        check("tick_align", found, 1);
    endtask

    // Presents a byte on a tick cycle so every bit, including the start bit, spans whole periods.
    task automatic issue(input logic [7:0] b, input frame_t f);
        align_tick();
        exp_q.push_back(f);
        fifo_data  = b;
        fifo_avail = 1'b1;
        exp_pops++;
        @(negedge clk_32);
        check("pop_strobe", fifo_pop, 1);
        @(posedge clk_32);
        #2;
        fifo_avail = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit found = 0;
        exp_dones++;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk_32);
            found = tx_done;
        end
        check("done_seen", found, 1);
    endtask

    initial begin
        // Reset with a byte waiting: nothing may leak out.
        reset = 1'b1; tx_enable = 1'b1; fifo_avail = 1'b1; fifo_data = 8'hFF; ucr = UCR_8N1_D1;
        repeat (3) @(posedge clk_32);
        @(negedge clk_32);
        check("rst_txd", txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_pop", fifo_pop, 0);
        @(posedge clk_32);
        #2;
        fifo_avail = 1'b0;
        reset = 1'b0;

        // 8N1 div16, tick every 4 clk: 64 clk per bit, tx_done on the 640th cycle of the frame.
        ucr = UCR_8N1_D16; tick_period = 4;
        issue(8'h55, mk(9, 16'h00AA, 64, 64, 0));
        wait_done(2000);
        check("t1_pops", pop_seen, exp_pops);

        // 7E2 div16, tick every 2 clk; UCR and enable change mid-frame.
        ucr = UCR_7E2_D16; tick_period = 2;
        issue(8'hC1, mk(9, 16'h0082, 32, 64, 0));
        ucr = UCR_8N1_D1; tx_enable = 1'b0; fifo_data = 8'h3C; fifo_avail = 1'b1;
        wait_done(2000);
        repeat (40) @(negedge clk_32);
        check("t2_no_pop_disabled", pop_seen, exp_pops);
        check("t2_idle_txd", txd, 1);
        @(posedge clk_32);
        #2;
        fifo_avail = 1'b0; tx_enable = 1'b1;

        // 5O1.5 div1, tick every 3 clk: stop is two ticks.
        ucr = UCR_5O15_D1; tick_period = 3;
        issue(8'hFF, mk(7, 16'h003E, 3, 6, 0));
        wait_done(500);

        // Two queued bytes, 8N1 div1, tick every clk: second pop the cycle after tx_done.
        ucr = UCR_8N1_D1; tick_period = 1;
`ifndef MFP_UART_TX_BREAK_EN
        tx_break = 1'b1;
`endif
        align_tick();
        exp_q.push_back(mk(9, 16'h0146, 1, 1, 0));
        exp_q.push_back(mk(9, 16'h001E, 1, 1, 0));
        fifo_data = 8'hA3; fifo_avail = 1'b1; exp_pops += 2;
        @(negedge clk_32);
        check("b2b_pop1", fifo_pop, 1);
        @(posedge clk_32);
        #2;
        fifo_data = 8'h0F;
        wait_done(100);
        @(negedge clk_32);
        check("b2b_pop2", fifo_pop, 1);
        @(posedge clk_32);
        #2;
        fifo_avail = 1'b0;
        wait_done(100);
        check("t4_pops", pop_seen, exp_pops);
        tx_break = 1'b0;

        // Sync format never pops and keeps the line high.
        ucr = UCR_SYNC; fifo_data = 8'h00; fifo_avail = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clk_32);
            check("sync_txd", txd, 1);
        end
        check("sync_pops", pop_seen, exp_pops);
        @(posedge clk_32);
        #2;
        fifo_avail = 1'b0;

        // Reset in DATA: line idles next cycle, byte dropped, no tx_done.
        ucr = UCR_8N1_D1; tick_period = 2;
        issue(8'h00, mk(9, 16'h0000, 2, 2, 1));
        repeat (4) @(posedge clk_32);
        #2;
        reset = 1'b1;
        @(posedge clk_32);
        #2;
        reset = 1'b0;
        @(negedge clk_32);
        check("midrst_txd", txd, 1);
        check("midrst_busy", tx_busy, 0);
        check("midrst_done", tx_done, 0);
        repeat (40) @(negedge clk_32);
        check("midrst_no_done", done_seen, exp_dones);

`ifdef MFP_UART_TX_BREAK_EN
        // Break requested mid-frame: frame completes, then line low without pops until release.
        ucr = UCR_8N1_D1; tick_period = 1;
        align_tick();
        exp_q.push_back(mk(9, 16'h0102, 1, 1, 0));
        fifo_data = 8'h81; fifo_avail = 1'b1; exp_pops++;
        @(negedge clk_32);
        check("brk_pop1", fifo_pop, 1);
        @(posedge clk_32);
        #2;
        tx_break = 1'b1; fifo_data = 8'h42;
        wait_done(100);
        @(negedge clk_32);
        check("brk_no_pop", fifo_pop, 0);
        @(negedge clk_32);
        check("brk_txd_low", txd, 0);
        repeat (10) @(negedge clk_32);
        check("brk_pops", pop_seen, exp_pops);
        check("brk_txd_hold", txd, 0);
        @(posedge clk_32);
        #2;
        tx_break = 1'b0;
        exp_q.push_back(mk(9, 16'h0084, 1, 1, 0));
        exp_pops++;
        @(negedge clk_32);
        check("rel_no_pop_yet", fifo_pop, 0);
        @(negedge clk_32);
        check("rel_txd_high", txd, 1);
        check("rel_pop", fifo_pop, 1);
        @(posedge clk_32);
        #2;
        fifo_avail = 1'b0;
        wait_done(100);
`endif

        repeat (20) @(posedge clk_32);
        check("queue_empty", 32'(exp_q.size()), 0);
        check("pops_total", pop_seen, exp_pops);
        check("dones_total", done_seen, exp_dones);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
